// File: rtl/watch_pkg.sv
// watch_pkg: shared field/direction encodings and FSM state type for the watch time-adjust path
package watch_pkg;
  localparam logic [1:0] FIELD_SEC  = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_HOUR = 2'b10;
  localparam logic [1:0] FIELD_INV  = 2'b11;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
endpackage

// File: rtl/watch_adj_sched_if.sv
// watch_adj_sched_if: UART burst command valid/ready channel into the adjust scheduler
interface watch_adj_sched_if #(parameter int CNT_W = 4);
  logic             valid;
  logic             ready;
  logic [1:0]       field;
  logic             dir;
  logic [CNT_W-1:0] count;
  modport master (output valid, field, dir, count, input ready);
  modport slave  (input valid, field, dir, count, output ready);
endinterface

// File: rtl/watch_tick_decode.sv
// watch_tick_decode: field/dir/issue to one-hot step pulse, bit order {hour_dn, hour_up, min_dn, min_up, sec_dn, sec_up}
module watch_tick_decode
  import watch_pkg::*;
(
  input  logic       issue,
  input  logic [1:0] field,
  input  logic       dir,
  output logic [5:0] tick
);
  always_comb begin
    tick[0] = issue && field == FIELD_SEC  && dir == DIR_UP;
    tick[1] = issue && field == FIELD_SEC  && dir == DIR_DOWN;
    tick[2] = issue && field == FIELD_MIN  && dir == DIR_UP;
    tick[3] = issue && field == FIELD_MIN  && dir == DIR_DOWN;
    tick[4] = issue && field == FIELD_HOUR && dir == DIR_UP;
    tick[5] = issue && field == FIELD_HOUR && dir == DIR_DOWN;
  end
endmodule

// File: rtl/watch_adj_sched.sv
// watch_adj_sched: arbitrates button single steps and UART step bursts into spaced one-hot tick pulses
module watch_adj_sched
  import watch_pkg::*;
#(
  parameter int GAP   = 2,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_req,
  input  logic [1:0]          btn_field,
  input  logic                btn_dir,
  watch_adj_sched_if.slave    uart,
  output logic                tick_sec_up,
  output logic                tick_sec_down,
  output logic                tick_min_up,
  output logic                tick_min_down,
  output logic                tick_hour_up,
  output logic                tick_hour_down,
  output logic                busy,
  output logic                btn_drop
);
  state_t           state, state_nx;
  logic             pend_valid, pend_dir;
  logic [1:0]       pend_field;
  logic [1:0]       cmd_field;
  logic             cmd_dir;
  logic [CNT_W-1:0] rem;
  logic [3:0]       gap_cnt;
  logic             hs, uart_go, pend_take, btn_ok, issue_nx, dir_nx, drop_q;
  logic [1:0]       fld_nx;
  logic [5:0]       tick_nx, tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state == ST_IDLE  ? ((pend_valid || uart_go) ? ST_ISSUE : ST_IDLE) :
               state == ST_ISSUE ? ST_WAIT :
               gap_cnt == 4'(GAP - 1) ? (rem != '0 ? ST_ISSUE : ST_IDLE) : ST_WAIT;
  end

  // ready is gated by reset so the channel stays closed while the block is held in reset
  always_comb begin
    uart.ready = rst && state == ST_IDLE && !pend_valid;
    hs         = uart.valid && uart.ready;
    uart_go    = hs && uart.count != '0 && uart.field != FIELD_INV;
    pend_take  = state == ST_IDLE && pend_valid;
    btn_ok     = btn_req && btn_field != FIELD_INV;
    busy       = state != ST_IDLE || pend_valid;
    issue_nx   = state_nx == ST_ISSUE;
    fld_nx     = state != ST_IDLE ? cmd_field : pend_valid ? pend_field : uart.field;
    dir_nx     = state != ST_IDLE ? cmd_dir : pend_valid ? pend_dir : uart.dir;
  end

  watch_tick_decode u_dec (
    .issue (issue_nx),
    .field (fld_nx),
    .dir   (dir_nx),
    .tick  (tick_nx)
  );

  // pending slot refills in the same cycle it is handed to the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_field <= '0;
      pend_dir   <= 1'b0;
      drop_q     <= 1'b0;
      cmd_field  <= '0;
      cmd_dir    <= 1'b0;
      rem        <= '0;
      gap_cnt    <= '0;
      tick_q     <= '0;
    end else begin
      pend_valid <= btn_ok || (pend_valid && !pend_take);
      if (btn_ok && (!pend_valid || pend_take)) begin
        pend_field <= btn_field;
        pend_dir   <= btn_dir;
      end
      drop_q <= btn_ok && pend_valid && !pend_take;
      if (pend_take) begin
        cmd_field <= pend_field;
        cmd_dir   <= pend_dir;
        rem       <= CNT_W'(1);
      end else if (hs) begin
        cmd_field <= uart.field;
        cmd_dir   <= uart.dir;
        rem       <= uart.count;
      end else if (state == ST_ISSUE) begin
        rem <= rem - CNT_W'(1);
      end
      gap_cnt <= state == ST_WAIT ? gap_cnt + 4'd1 : '0;
      tick_q  <= tick_nx;
    end
  end

  assign {tick_hour_down, tick_hour_up, tick_min_down, tick_min_up, tick_sec_down, tick_sec_up} = tick_q;
  assign btn_drop = drop_q;
endmodule

// File: tb/tb_watch_adj_sched.sv
// tb_watch_adj_sched: directed cycle-by-cycle checks of tick timing, arbitration, drops and reset abort
module tb_watch_adj_sched;
  localparam logic [5:0] SEC_UP = 6'b000001, SEC_DN = 6'b000010, MIN_UP = 6'b000100;
  localparam logic [5:0] MIN_DN = 6'b001000, HOUR_UP = 6'b010000, HOUR_DN = 6'b100000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_req = 1'b0;
  logic [1:0] btn_field = 2'b00;
  logic btn_dir = 1'b0;
  logic tick_sec_up, tick_sec_down, tick_min_up, tick_min_down, tick_hour_up, tick_hour_down;
  logic busy, btn_drop;
  logic [5:0] ticks;
  logic [8:0] outs;
  int n_run = 0;
  int n_fail = 0;

  watch_adj_sched_if #(.CNT_W(4)) u_if ();

  watch_adj_sched #(.GAP(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_req        (btn_req),
    .btn_field      (btn_field),
    .btn_dir        (btn_dir),
    .uart           (u_if),
    .tick_sec_up    (tick_sec_up),
    .tick_sec_down  (tick_sec_down),
    .tick_min_up    (tick_min_up),
    .tick_min_down  (tick_min_down),
    .tick_hour_up   (tick_hour_up),
    .tick_hour_down (tick_hour_down),
    .busy           (busy),
    .btn_drop       (btn_drop)
  );

  assign ticks = {tick_hour_down, tick_hour_up, tick_min_down, tick_min_up, tick_sec_down, tick_sec_up};
  assign outs  = {ticks, u_if.ready, busy, btn_drop};

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic btn(input logic [1:0] f, input logic d);
    btn_req = 1'b1; btn_field = f; btn_dir = d;
  endtask

  task automatic cmd(input logic [1:0] f, input logic d, input logic [3:0] n);
    u_if.valid = 1'b1; u_if.field = f; u_if.dir = d; u_if.count = n;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    btn_req = 1'b0;
    u_if.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    u_if.valid = 1'b0; u_if.field = 2'b00; u_if.dir = 1'b0; u_if.count = 4'd0;
    @(negedge clk);
    check("reset outs", int'(outs), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset outs2", int'(outs), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) btn(2'b01, 1'b1);
      @(negedge clk);
      check($sformatf("t1 tick c%0d", c), int'(ticks), c == 2 ? int'(MIN_UP) : 0);
      check($sformatf("t1 busy c%0d", c), int'(busy), int'(c >= 1 && c <= 4));
      check($sformatf("t1 ready c%0d", c), int'(u_if.ready), int'(c == 0 || c >= 5));
      next_cycle();
    end
    idle(2);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) cmd(2'b10, 1'b0, 4'd3);
      @(negedge clk);
      check($sformatf("t2 tick c%0d", c), int'(ticks), (c == 1 || c == 4 || c == 7) ? int'(HOUR_DN) : 0);
      check($sformatf("t2 ready c%0d", c), int'(u_if.ready), int'(c == 0 || c >= 10));
      check($sformatf("t2 busy c%0d", c), int'(busy), int'(c >= 1 && c <= 9));
      next_cycle();
    end
    idle(2);
    for (int c = 0; c < 16; c++) begin
      if (c == 0) cmd(2'b10, 1'b0, 4'd3);
      if (c == 2) btn(2'b00, 1'b1);
      @(negedge clk);
      check($sformatf("t3 tick c%0d", c), int'(ticks),
            (c == 1 || c == 4 || c == 7) ? int'(HOUR_DN) : c == 11 ? int'(SEC_UP) : 0);
      check($sformatf("t3 ready c%0d", c), int'(u_if.ready), int'(c == 0 || c >= 14));
      check($sformatf("t3 busy c%0d", c), int'(busy), int'(c >= 1 && c <= 13));
      next_cycle();
    end
    idle(2);
    for (int c = 0; c < 16; c++) begin
      if (c == 0) cmd(2'b00, 1'b1, 4'd3);
      if (c == 2) btn(2'b01, 1'b1);
      if (c == 5) btn(2'b00, 1'b0);
      @(negedge clk);
      check($sformatf("t4 tick c%0d", c), int'(ticks),
            (c == 1 || c == 4 || c == 7) ? int'(SEC_UP) : c == 11 ? int'(MIN_UP) : 0);
      check($sformatf("t4 drop c%0d", c), int'(btn_drop), int'(c == 6));
      next_cycle();
    end
    idle(2);
    for (int c = 0; c < 6; c++) begin
      if (c == 0) cmd(2'b01, 1'b1, 4'd0);
      if (c == 1) cmd(2'b11, 1'b1, 4'd5);
      if (c == 2) btn(2'b11, 1'b0);
      @(negedge clk);
      check($sformatf("t5 outs c%0d", c), int'(outs), 9'b000000_1_0_0);
      next_cycle();
    end
    idle(1);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin cmd(2'b10, 1'b1, 4'd2); btn(2'b01, 1'b0); end
      @(negedge clk);
      check($sformatf("t7 tick c%0d", c), int'(ticks),
            (c == 1 || c == 4) ? int'(HOUR_UP) : c == 8 ? int'(MIN_DN) : 0);
      check($sformatf("t7 ready c%0d", c), int'(u_if.ready), int'(c == 0 || c >= 11));
      next_cycle();
    end
    idle(2);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) cmd(2'b01, 1'b0, 4'd5);
      if (c == 5) rst = 1'b0;
      if (c == 7) rst = 1'b1;
      @(negedge clk);
      if (c < 5)
        check($sformatf("t6 tick c%0d", c), int'(ticks), (c == 1 || c == 4) ? int'(MIN_DN) : 0);
      else
        check($sformatf("t6 outs c%0d", c), int'(outs), c == 7 ? 9'b000000_1_0_0 : 0);
      next_cycle();
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("t6 post c%0d", c), int'(outs), 9'b000000_1_0_0);
      next_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
